// File: rtl/rd_wb_ctrl_pkg.sv
// Shared types for the register writeback controller: writeback source
// select, controller states and a small decode helper.
package rdPkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RD_IMM  = 2'd0,
    RD_PCP4 = 2'd1,
    RD_ALU  = 2'd2,
    RD_MEM  = 2'd3
  } rd_sel;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    ERR       = 2'd2
  } wb_state;

  // A writeback from memory needs the load handshake instead of a direct write
  function automatic logic is_load(input rd_sel kind);
    return kind == RD_MEM;
  endfunction

endpackage

// File: rtl/rd_wb_ctrl_timer.sv
// Saturating wait counter for outstanding loads. 'expired' flags the cycle
// whose increment brings the count up to LIMIT, so the caller can leave the
// wait state after exactly LIMIT counted cycles.
module wb_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count enabled cycles, holding at LIMIT so the value never wraps
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && count != TOP) begin
      count <= count + 1'b1;
    end
  end

  // The current enabled cycle is the one that reaches LIMIT
  always_comb begin
    expired = en && (count == LAST);
  end

endmodule

// File: rtl/rd_wb_ctrl.sv
// Register writeback controller: direct writes for immediate/PC+4/ALU
// results, a stalled request/acknowledge handshake for loads, and a
// timeout that abandons a load the memory never answers.
module rd_wb_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  rdPkg::rd_sel wb_kind,
  input  logic [4:0]  rd_addr,
  input  logic        mem_ack,
  output rdPkg::rd_sel rd_sel,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic        mem_req,
  output logic        stall,
  output logic        timeout_err
);

  rdPkg::wb_state state;
  logic [4:0]     load_addr;
  logic           timer_clr;
  logic           timer_en;
  logic           timer_expired;

  // The wait counter only runs while a load is outstanding and unanswered;
  // it is held at zero whenever the controller is idle
  always_comb begin
    timer_clr = (state == rdPkg::IDLE);
    timer_en  = (state == rdPkg::LOAD_WAIT) && !mem_ack;
  end

  wb_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  // State sequencing; an ack beats a simultaneous timeout, and new
  // requests are only accepted from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= rdPkg::IDLE;
      load_addr <= '0;
    end else begin
      case (state)
        rdPkg::IDLE: begin
          if (instr_valid && rdPkg::is_load(wb_kind)) begin
            load_addr <= rd_addr;
            state     <= rdPkg::LOAD_WAIT;
          end
        end
        rdPkg::LOAD_WAIT: begin
          if (mem_ack) begin
            state <= rdPkg::IDLE;
          end else if (timer_expired) begin
            state <= rdPkg::ERR;
          end
        end
        rdPkg::ERR: begin
          state <= rdPkg::IDLE;
        end
        default: begin
          state <= rdPkg::IDLE;
        end
      endcase
    end
  end

  // Output decode; reset overrides everything, and writes to x0 are dropped
  always_comb begin
    rd_sel      = rdPkg::RD_ALU;
    rd_we       = 1'b0;
    rd_waddr    = '0;
    mem_req     = 1'b0;
    stall       = 1'b0;
    timeout_err = 1'b0;
    if (!rst) begin
      case (state)
        rdPkg::IDLE: begin
          if (instr_valid) begin
            if (rdPkg::is_load(wb_kind)) begin
              rd_sel  = rdPkg::RD_MEM;
              mem_req = 1'b1;
              stall   = 1'b1;
            end else begin
              rd_sel   = wb_kind;
              rd_waddr = rd_addr;
              rd_we    = (rd_addr != '0);
            end
          end
        end
        rdPkg::LOAD_WAIT: begin
          rd_sel   = rdPkg::RD_MEM;
          rd_waddr = load_addr;
          if (mem_ack) begin
            rd_we = (load_addr != '0);
          end else begin
            mem_req = 1'b1;
            stall   = 1'b1;
          end
        end
        rdPkg::ERR: begin
          timeout_err = 1'b1;
        end
        default: begin
          rd_sel = rdPkg::RD_ALU;
        end
      endcase
    end
  end

endmodule
